dot_prod: RTL and testbench

Sequential unsigned dot-product engine. Accepts a start command with a vector length, then consumes operand pairs over a valid/ready stream. Each pair is multiplied by shift-add, one bit per cycle, directly into a guarded accumulator. It reports the final sum with a one-cycle done pulse. It sits downstream of operand-fetch logic and upstream of result consumers, reusing the team's serial-multiply approach without a separate product register.

---
 rtl/dot_prod_pkg.sv | 26 ++
 rtl/dot_prod.sv | 94 +++++++++
 tb/tb_dot_prod.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and sizing helpers for the serial dot-product engine.
// Keeps the FSM encoding and derived widths in one place.
package dot_prod_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CALC,
      DONE
   } state_t;

   localparam int W_DEF     = 8;
   localparam int N_MAX_DEF = 16;

   function automatic int guard_bits(input int n_max);
      return $clog2(n_max);
   endfunction

   function automatic int len_bits(input int n_max);
      return $clog2(n_max + 1);
   endfunction

   localparam int G_DEF  = guard_bits(N_MAX_DEF);
   localparam int LW_DEF = len_bits(N_MAX_DEF);

endpackage

// File: rtl/dot_prod.sv
// Unsigned dot-product engine: one operand pair at a time, shift-add
// multiply accumulating straight into a guard-extended accumulator.
module dot_prod
   import dot_prod_pkg::*;
#(
   parameter  int W     = W_DEF,
   parameter  int N_MAX = N_MAX_DEF,
   localparam int G     = guard_bits(N_MAX),
   localparam int LW    = len_bits(N_MAX),
   localparam int SW    = 2 * W + G
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          in_val,
   output logic          in_rdy,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sum
);

   localparam int          CW     = $clog2(W + 1);
   localparam logic [LW-1:0] LEN_MAX = LW'(N_MAX);

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    a_reg;
   logic [SW-1:0]   b_reg;
   logic [SW-1:0]   acc;
   logic [CW-1:0]   ctr;
   logic [LW-1:0]   rem;
   logic [LW-1:0]   len_clamp;
   logic            last_bit;

   assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
   assign last_bit  = (ctr == CW'(1));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = (len == '0) ? DONE : LOAD;
         LOAD: if (in_val) state_nxt = CALC;
         CALC: if (last_bit) state_nxt = (rem == LW'(1)) ? DONE : LOAD;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         ctr   <= '0;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  if (len != '0) rem <= len_clamp;
               end
            end
            LOAD: begin
               if (in_val) begin
                  a_reg <= a;
                  b_reg <= {{(W + G){1'b0}}, b};
                  ctr   <= CW'(W);
               end
            end
            CALC: begin
               // Fixed W-cycle pass; zero multiplier bits just skip the add.
               if (a_reg[0]) acc <= acc + b_reg;
               a_reg <= a_reg >> 1;
               b_reg <= b_reg << 1;
               ctr   <= ctr - CW'(1);
               if (last_bit) rem <= rem - LW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_rdy = (state == LOAD);
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign sum    = acc;

endmodule

// File: tb/tb_dot_prod.sv
// Directed bench for dot_prod (W=8, N_MAX=16) with hand-computed
// sums and cycle positions relative to the accepted start.
module tb_dot_prod;
   import dot_prod_pkg::*;

   localparam int W     = 8;
   localparam int N_MAX = 16;
   localparam int LW    = 5;
   localparam int SW    = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          in_val;
   logic          in_rdy;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [SW-1:0] sum;

   int n_pass = 0;
   int n_chk  = 0;
   int va [N_MAX];
   int vb [N_MAX];
   int rdy_q [$];
   int done_at;
   logic [SW-1:0] got_sum;
   bit aborted;

   always #5 clk = ~clk;

   dot_prod #(.W(W), .N_MAX(N_MAX)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .len    (len),
      .in_val (in_val),
      .in_rdy (in_rdy),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .sum    (sum)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
   endtask

   // Cycle t = the cycle start is presented; rel counts from there.
   task automatic run(input int n_len, input int np, input int stall,
                      input int mid_start, input int rst_at,
                      output bit ab);
      int idx = 0;
      int st  = 0;
      int rel = 0;
      ab = 1'b0;
      done_at = -1;
      got_sum = '0;
      rdy_q.delete();
      start  = 1'b1;
      len    = LW'(n_len);
      in_val = 1'b0;
      tick();
      start = 1'b0;
      len   = '0;
      rel   = 1;
      while (rel < 400) begin
         if (done) begin
            done_at = rel;
            got_sum = sum;
            break;
         end
         if (in_rdy) rdy_q.push_back(rel);
         start = (rel == mid_start);
         len   = start ? LW'(5) : '0;
         if (rel == rst_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            ab  = 1'b1;
            return;
         end
         in_val = 1'b0;
         a = 8'h5A;
         b = 8'hA5;
         if (idx < np) begin
            if (in_rdy && st < stall) st++;
            else begin
               in_val = 1'b1;
               if (in_rdy) begin
                  a = 8'(va[idx]);
                  b = 8'(vb[idx]);
                  idx++;
                  st = 0;
               end
            end
         end
         tick();
         rel++;
      end
      start  = 1'b0;
      in_val = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      len = '0;
      in_val = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      check("rst_in_rdy", 32'(in_rdy), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sum", 32'(sum), 0);
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_rdy", 32'(in_rdy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_sum", 32'(sum), 0);

      va[0] = 3;   vb[0] = 4;
      va[1] = 5;   vb[1] = 6;
      va[2] = 255; vb[2] = 255;
      run(3, 3, 0, -1, -1, aborted);
      check("basic_done_at", 32'(done_at), 28);
      check("basic_sum", 32'(got_sum), 65067);
      check("basic_rdy_cnt", 32'(rdy_q.size()), 3);
      if (rdy_q.size() == 3) begin
         check("basic_rdy0", 32'(rdy_q[0]), 1);
         check("basic_rdy1", 32'(rdy_q[1]), 10);
         check("basic_rdy2", 32'(rdy_q[2]), 19);
      end
      tick();
      check("basic_busy_fall", 32'(busy), 0);
      check("basic_done_pulse", 32'(done), 0);
      check("basic_sum_hold", 32'(sum), 65067);

      for (int i = 0; i < N_MAX; i++) begin
         va[i] = 255;
         vb[i] = 255;
      end
      run(16, 16, 0, -1, -1, aborted);
      check("full_done_at", 32'(done_at), 145);
      check("full_sum", 32'(got_sum), 1040400);
      tick();
      run(20, 16, 0, -1, -1, aborted);
      check("clamp_done_at", 32'(done_at), 145);
      check("clamp_sum", 32'(got_sum), 1040400);
      check("clamp_pairs", 32'(rdy_q.size()), 16);
      tick();

      va[0] = 7;  vb[0] = 9;
      va[1] = 10; vb[1] = 10;
      run(2, 2, 3, -1, -1, aborted);
      check("bp_done_at", 32'(done_at), 25);
      check("bp_sum", 32'(got_sum), 163);
      tick();

      run(0, 0, 0, -1, -1, aborted);
      check("zero_done_at", 32'(done_at), 1);
      check("zero_sum", 32'(got_sum), 0);
      tick();

      va[0] = 3; vb[0] = 4;
      va[1] = 5; vb[1] = 6;
      run(2, 2, 0, 4, -1, aborted);
      check("ign_done_at", 32'(done_at), 19);
      check("ign_sum", 32'(got_sum), 42);
      tick();
      check("ign_idle", 32'(busy), 0);
      tick();
      check("ign_still_idle", 32'(busy), 0);

      va[2] = 255; vb[2] = 255;
      run(3, 3, 0, -1, 14, aborted);
      check("mrst_taken", 32'(aborted), 1);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_rdy", 32'(in_rdy), 0);
      check("mrst_done", 32'(done), 0);
      check("mrst_sum", 32'(sum), 0);
      va[0] = 12; vb[0] = 12;
      run(1, 1, 0, -1, -1, aborted);
      check("fresh_done_at", 32'(done_at), 10);
      check("fresh_sum", 32'(got_sum), 144);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
